// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               Holds the loader state encoding, the instruction field layout
//               {op[18:16], A[15:8], B[7:0]} and the maximum word count.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int INS_W     = 19;
  localparam int OP_W      = 3;
  localparam int DATA_W    = 8;

  localparam int OP_MSB    = 18;
  localparam int OP_LSB    = 16;
  localparam int A_MSB     = 15;
  localparam int A_LSB     = 8;
  localparam int B_MSB     = 7;
  localparam int B_LSB     = 0;

  localparam int MAX_WORDS = 64;

  // CSUM is only ever entered when the checksum option is compiled in.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    B0   = 3'd2,
    B1   = 3'd3,
    B2   = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6,
    CSUM = 3'd7
  } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream handshake plus instruction-memory write bus.
//               slave  : the loader (accepts the stream, drives memory writes)
//               master : the stream source / memory-side observer
// Signals     : in_data, in_valid (to loader), in_ready (from loader),
//               mem_we, mem_addr, mem_wdata (from loader)
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int INS_W  = 19
);
  import imem_loader_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [INS_W-1:0]  mem_wdata;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader_csum.sv
`default_nettype none
// ============================================================================
// Module      : loader_csum
// Description : XOR accumulator for the loader stream checksum. Clears on
//               reset or clr, folds din in when acc_en, and compares the
//               running sum against din.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               clr         - restart the accumulation (new load)
//               acc_en      - fold din into the running XOR
//               din         - stream byte
//               match       - running XOR equals din (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module loader_csum
  import imem_loader_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         acc_en,
  input  logic [W-1:0] din,
  output logic         match
);

  logic [W-1:0] sum;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum <= '0;
    end else if (acc_en) begin
      sum <= sum ^ din;
    end
  end

  assign match = (sum == din);

endmodule : loader_csum
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Instruction-memory writer. Takes a header byte (word count,
//               0 = 64) followed by three bytes per word (op, A, B), writes
//               each assembled word to consecutive addresses from 0, holds
//               the CPU via busy, pulses done on success and raises a sticky
//               err on a malformed stream.
//               Optional checksum byte after the last word when the macro
//               IMEM_LOADER_CSUM_EN is defined (XOR of header and payload).
// Ports       : clk, reset    - clock, synchronous active-high reset
//               start         - begin a load (honoured only in IDLE)
//               bus (slave)   - byte stream in, memory write bus out
//               busy          - load in progress
//               done          - one-cycle success pulse
//               err           - sticky error, cleared by reset or start
//               words_loaded  - words written in the current/last load
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int INS_W  = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [6:0]    words_loaded
);

  import imem_loader_pkg::*;

  // Header bytes above DEPTH are rejected; a zero header means a full load.
  localparam logic [DATA_W-1:0] MAX_HDR = DATA_W'(DEPTH);
  localparam logic [6:0]        FULL_N  = 7'(DEPTH);

  state_t              state;
  logic [6:0]          n_words;
  logic [OP_W-1:0]     op;
  logic [DATA_W-1:0]   a_byte;
  logic [ADDR_W-1:0]   addr;
  logic [INS_W-1:0]    wdata;
  logic                in_ready;
  logic                accept;
  logic [6:0]          next_count;

  // in_ready and mem_we decode straight from state; reset masks them so no
  // byte is taken and no write is issued in a reset cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      HDR, B0, B1, B2: in_ready = !reset;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:            in_ready = !reset;
`endif
      default:         in_ready = 1'b0;
    endcase
  end

  assign accept        = bus.in_valid && in_ready;
  assign next_count    = words_loaded + 7'd1;

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = (state == WR) && !reset;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;

`ifdef IMEM_LOADER_CSUM_EN
  logic csum_clr;
  logic csum_acc;
  logic csum_match;

  // Every accepted byte except the checksum itself goes into the sum.
  assign csum_clr = (state == IDLE) && start;
  assign csum_acc = accept && (state != CSUM);

  loader_csum #(
    .W (DATA_W)
  ) u_csum (
    .clk    (clk),
    .reset  (reset),
    .clr    (csum_clr),
    .acc_en (csum_acc),
    .din    (bus.in_data),
    .match  (csum_match)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 7'd0;
      addr         <= '0;
      wdata        <= '0;
      n_words      <= 7'd0;
      op           <= '0;
      a_byte       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err          <= 1'b0;
            words_loaded <= 7'd0;
            addr         <= '0;
            busy         <= 1'b1;
            state        <= HDR;
          end
        end

        HDR: begin
          if (accept) begin
            if (bus.in_data > MAX_HDR) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              n_words <= (bus.in_data == '0) ? FULL_N : bus.in_data[6:0];
              state   <= B0;
            end
          end
        end

        B0: begin
          if (accept) begin
            // Only three opcode bits exist; anything above them is corrupt.
            if (|bus.in_data[DATA_W-1:OP_W]) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              op    <= bus.in_data[OP_W-1:0];
              state <= B1;
            end
          end
        end

        B1: begin
          if (accept) begin
            a_byte <= bus.in_data;
            state  <= B2;
          end
        end

        B2: begin
          if (accept) begin
            wdata[OP_MSB:OP_LSB] <= op;
            wdata[A_MSB:A_LSB]   <= a_byte;
            wdata[B_MSB:B_LSB]   <= bus.in_data;
            state                <= WR;
          end
        end

        WR: begin
          // The address wraps to 0 only after the final (64th) word.
          words_loaded <= next_count;
          addr         <= addr + ADDR_W'(1);
          if (next_count == n_words) begin
`ifdef IMEM_LOADER_CSUM_EN
            state <= CSUM;
`else
            done  <= 1'b1;
            state <= DONE;
`endif
          end else begin
            state <= B0;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

`ifdef IMEM_LOADER_CSUM_EN
        CSUM: begin
          if (accept) begin
            if (csum_match) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
`endif

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : imem_loader
`default_nettype wire
